// File: rtl/game_state_ctrl.sv
// game_state_ctrl
//
// Game-flow controller sitting behind the collision detector. It runs the
// IDLE / PLAYING / CRASH / GAME_OVER state machine. It also keeps the lives
// counter, the saturating survival score and the post-crash invulnerability
// timer. Every output is registered.
//
// Ports
//   clk            system clock
//   reset          asynchronous, active-high reset
//   frame_tick_i   one-cycle pulse per video frame
//   start_btn_i    start button level (synchronised, debounced)
//   collision_i    overlap level from the collision detector
//   state_o        00 IDLE, 01 PLAYING, 10 CRASH, 11 GAME_OVER
//   lives_o        remaining lives
//   score_o        frames survived, saturating
//   freeze_o       traffic/player motion halted
//   blink_o        player sprite hide phase
//   crash_pulse_o  one-cycle pulse per registered crash
//   game_over_o    high in GAME_OVER
module game_state_ctrl #(
  parameter int unsigned LIVES       = 3,
  parameter logic [7:0]  CRASH_TICKS = 8'd120,
  parameter int unsigned SCORE_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick_i,
  input  logic               start_btn_i,
  input  logic               collision_i,
  output logic [1:0]         state_o,
  output logic [2:0]         lives_o,
  output logic [SCORE_W-1:0] score_o,
  output logic               freeze_o,
  output logic               blink_o,
  output logic               crash_pulse_o,
  output logic               game_over_o
);

  localparam logic [1:0] StIdle  = 2'b00;
  localparam logic [1:0] StPlay  = 2'b01;
  localparam logic [1:0] StCrash = 2'b10;
  localparam logic [1:0] StOver  = 2'b11;

  localparam logic [2:0]         LivesInit = 3'(LIVES);
  localparam logic [SCORE_W-1:0] ScoreOne  = SCORE_W'(1);

  logic [1:0]         state_q, state_d;
  logic [2:0]         lives_q, lives_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [7:0]         timer_q, timer_d;
  logic               pulse_q, pulse_d;
  logic               freeze_q, blink_q, over_q;
  logic               start_q;
  logic               start_rise;

  // History resets to 1 so a button held through reset is not seen as a press.
  assign start_rise = start_btn_i & ~start_q;

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    score_d = score_q;
    timer_d = timer_q;
    pulse_d = 1'b0;
    case (state_q)
      StIdle, StOver: begin
        if (start_rise) begin
          state_d = StPlay;
          lives_d = LivesInit;
          score_d = '0;
          timer_d = 8'd0;
        end
      end
      StPlay: begin
        // Collision takes priority over a same-cycle frame tick.
        if (collision_i) begin
          pulse_d = 1'b1;
          if (lives_q > 3'd1) begin
            state_d = StCrash;
            lives_d = lives_q - 3'd1;
            timer_d = CRASH_TICKS;
          end else begin
            state_d = StOver;
            lives_d = 3'd0;
          end
        end else if (frame_tick_i && (score_q != '1)) begin
          score_d = score_q + ScoreOne;
        end
      end
      StCrash: begin
        // Collision is ignored here; only frame ticks advance the timer.
        if (frame_tick_i) begin
          if (timer_q <= 8'd1) begin
            state_d = StPlay;
            timer_d = 8'd0;
          end else begin
            timer_d = timer_q - 8'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      lives_q  <= LivesInit;
      score_q  <= '0;
      timer_q  <= 8'd0;
      pulse_q  <= 1'b0;
      freeze_q <= 1'b1;
      blink_q  <= 1'b0;
      over_q   <= 1'b0;
      start_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      lives_q  <= lives_d;
      score_q  <= score_d;
      timer_q  <= timer_d;
      pulse_q  <= pulse_d;
      // Derived outputs are registered from next-state so they line up with state_o.
      freeze_q <= (state_d != StPlay);
      blink_q  <= (state_d == StCrash) & timer_d[2];
      over_q   <= (state_d == StOver);
      start_q  <= start_btn_i;
    end
  end

  assign state_o       = state_q;
  assign lives_o       = lives_q;
  assign score_o       = score_q;
  assign freeze_o      = freeze_q;
  assign blink_o       = blink_q;
  assign crash_pulse_o = pulse_q;
  assign game_over_o   = over_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Testbench for game_state_ctrl with LIVES=3, CRASH_TICKS=4.
module tb_game_state_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic        start_btn;
  logic        collision;
  logic [1:0]  state;
  logic [2:0]  lives;
  logic [15:0] score;
  logic        freeze;
  logic        blink;
  logic        crash_pulse;
  logic        game_over;

  int n_checks = 0;
  int n_fail   = 0;

  game_state_ctrl #(
    .LIVES       (3),
    .CRASH_TICKS (8'd4),
    .SCORE_W     (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .frame_tick_i  (frame_tick),
    .start_btn_i   (start_btn),
    .collision_i   (collision),
    .state_o       (state),
    .lives_o       (lives),
    .score_o       (score),
    .freeze_o      (freeze),
    .blink_o       (blink),
    .crash_pulse_o (crash_pulse),
    .game_over_o   (game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s, c, t;
    logic [1:0]  st;
    logic [2:0]  lv;
    logic [15:0] sc;
    logic        fz, bl, cp, go;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic s, input logic c, input logic t, input logic [1:0] st,
                     input logic [2:0] lv, input logic [15:0] sc, input logic fz,
                     input logic bl, input logic cp, input logic go);
    vec_t v;
    v.s = s; v.c = c; v.t = t; v.st = st; v.lv = lv; v.sc = sc;
    v.fz = fz; v.bl = bl; v.cp = cp; v.go = go;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [1:0] st, input logic [2:0] lv,
                       input logic [15:0] sc, input logic fz, input logic bl,
                       input logic cp, input logic go);
    logic [24:0] got, exp;
    got = {state, lives, score, freeze, blink, crash_pulse, game_over};
    exp = {st, lv, sc, fz, bl, cp, go};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got st=%b lv=%0d sc=%h fz=%b bl=%b cp=%b go=%b, expected st=%b lv=%0d sc=%h fz=%b bl=%b cp=%b go=%b",
               name, state, lives, score, freeze, blink, crash_pulse, game_over,
               st, lv, sc, fz, bl, cp, go);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic c, input logic t);
    start_btn  = s;
    collision  = c;
    frame_tick = t;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0);

    // st: 0 IDLE, 1 PLAY, 2 CRASH, 3 OVER
    add(1, 0, 0, 2'd0, 3, 16'd0, 1, 0, 0, 0); // start held through reset
    add(1, 0, 1, 2'd0, 3, 16'd0, 1, 0, 0, 0); // tick in IDLE does nothing
    add(0, 0, 0, 2'd0, 3, 16'd0, 1, 0, 0, 0);
    add(1, 0, 0, 2'd1, 3, 16'd0, 0, 0, 0, 0); // rising edge starts game
    for (int i = 1; i <= 10; i++) add(1, 0, 1, 2'd1, 3, 16'(i), 0, 0, 0, 0);
    add(1, 0, 0, 2'd1, 3, 16'd10, 0, 0, 0, 0);
    add(0, 1, 0, 2'd2, 2, 16'd10, 1, 1, 1, 0); // crash: timer=4, blink=bit2
    add(0, 1, 1, 2'd2, 2, 16'd10, 1, 0, 0, 0); // timer 3, collision ignored
    add(0, 1, 1, 2'd2, 2, 16'd10, 1, 0, 0, 0); // timer 2
    add(0, 1, 1, 2'd2, 2, 16'd10, 1, 0, 0, 0); // timer 1
    add(0, 0, 0, 2'd2, 2, 16'd10, 1, 0, 0, 0);
    add(1, 0, 0, 2'd2, 2, 16'd10, 1, 0, 0, 0); // start_rise ignored in CRASH
    add(1, 0, 1, 2'd1, 2, 16'd10, 0, 0, 0, 0); // 4th tick exits
    add(0, 0, 1, 2'd1, 2, 16'd11, 0, 0, 0, 0);
    add(0, 1, 1, 2'd2, 1, 16'd11, 1, 1, 1, 0); // collision beats tick
    add(0, 0, 1, 2'd2, 1, 16'd11, 1, 0, 0, 0);
    add(0, 0, 1, 2'd2, 1, 16'd11, 1, 0, 0, 0);
    add(0, 0, 1, 2'd2, 1, 16'd11, 1, 0, 0, 0);
    add(0, 0, 1, 2'd1, 1, 16'd11, 0, 0, 0, 0);
    add(0, 1, 0, 2'd3, 0, 16'd11, 1, 0, 1, 1); // last life -> GAME_OVER
    add(0, 1, 1, 2'd3, 0, 16'd11, 1, 0, 0, 1); // held, no second pulse
    add(1, 0, 0, 2'd1, 3, 16'd0, 0, 0, 0, 0);  // restart
    add(0, 0, 1, 2'd1, 3, 16'd1, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    check("reset_values", 2'd0, 3, 16'd0, 1, 0, 0, 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].s, vecs[i].c, vecs[i].t);
      step();
      check($sformatf("vec%0d", i), vecs[i].st, vecs[i].lv, vecs[i].sc,
            vecs[i].fz, vecs[i].bl, vecs[i].cp, vecs[i].go);
    end

    // Reset asserted mid-crash with timer=2.
    drive(0, 1, 0);
    step();
    check("crash_entry", 2'd2, 2, 16'd1, 1, 1, 1, 0);
    drive(0, 0, 1);
    step();
    step();
    check("crash_timer2", 2'd2, 2, 16'd1, 1, 0, 0, 0);
    drive(1, 0, 0);
    reset = 1'b1;
    #2;
    check("async_reset", 2'd0, 3, 16'd0, 1, 0, 0, 0);
    step();
    step();
    reset = 1'b0;
    repeat (3) step();
    check("held_start_no_game", 2'd0, 3, 16'd0, 1, 0, 0, 0);
    drive(0, 0, 0);
    step();
    drive(1, 0, 0);
    step();
    check("fresh_start", 2'd1, 3, 16'd0, 0, 0, 0, 0);

    // Saturation: tick every cycle up to FFFE, then three more.
    drive(1, 0, 1);
    repeat (65534) step();
    check("score_fffe", 2'd1, 3, 16'hFFFE, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("score_sat%0d", i), 2'd1, 3, 16'hFFFF, 0, 0, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/game_state_ctrl.md
# game_state_ctrl

Game-flow controller directly downstream of the car/traffic collision detector. It consumes the registered `collision` level and a per-frame tick, and runs the IDLE/PLAYING/CRASH/GAME_OVER state machine. It also keeps the lives counter, the survival score and the post-crash invulnerability timer. Its outputs drive traffic freeze, player-sprite blink, the HUD (score, lives) and the crash sound trigger.

## Interface
- `LIVES`, 3: lives at game start; legal range 1..7.
- `CRASH_TICKS`, 8'd120: frame ticks spent in CRASH; legal range 1..255.
- `SCORE_W`, 16: score counter width.

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `frame_tick`  in  1  one-cycle pulse per video frame.
- `start_btn`  in  1  start button level, already synchronised and debounced.
- `collision`  in  1  overlap level from the collision detector.
- `state`  out  2  00 IDLE, 01 PLAYING, 10 CRASH, 11 GAME_OVER.
- `lives`  out  3  remaining lives.
- `score`  out  SCORE_W  frames survived, saturating.
- `freeze`  out  1  traffic/player motion halted.
- `blink`  out  1  player sprite hide phase.
- `crash_pulse`  out  1  one-cycle pulse when a crash is registered.
- `game_over`  out  1  high in GAME_OVER.

## Operation
- All outputs are registered.
- Reset values:
  - `state` = IDLE
  - `lives` = LIVES
  - `score` = 0
  - `freeze` = 1
  - `blink` = 0
  - `crash_pulse` = 0
  - `game_over` = 0
  - internal timer = 0
  - `start_btn` history register = 1, so a button held through reset does not start a game.
- `start_rise` = `start_btn` & ~previous `start_btn`, using that history register.
- IDLE: on `start_rise` -> PLAYING; `lives` ← LIVES; `score` ← 0.
- PLAYING:
  - `collision`=1 sampled at a clock edge, with `lives`>1 -> CRASH; `lives` ← `lives`-1; timer ← CRASH_TICKS; `crash_pulse`=1 for one cycle.
  - `collision`=1 with `lives`==1 -> GAME_OVER; `lives` ← 0; `crash_pulse`=1 for one cycle.
  - Otherwise, on `frame_tick`: `score` ← `score`+1, saturating at all-ones.
  - `collision` and `frame_tick` in the same cycle: the collision wins and `score` does not increment.
- CRASH:
  - `collision` is ignored (invulnerability).
  - Each `frame_tick` decrements the timer.
  - `frame_tick` with timer==1 -> PLAYING, timer ← 0.
  - `score` is frozen.
- Return from CRASH while still overlapping: `collision` is level-sensitive, so the next edge in PLAYING registers a new crash. This is intended.
- GAME_OVER: `score` and `lives`=0 held; on `start_rise` -> PLAYING with `lives` ← LIVES and `score` ← 0.
- `start_rise` in PLAYING or CRASH: ignored.
- `freeze` = 1 in IDLE, CRASH and GAME_OVER; 0 in PLAYING.
- `blink` = timer bit 2 while in CRASH, else 0.
- `game_over` = (`state`==GAME_OVER).
- Width rules:
  - `lives` is never decremented below 0.
  - `score` never wraps.
  - The timer is 8 bits and is never decremented below 0.

## Timing
- Latency: a `collision` sampled at edge N shows as the new `state`/`lives`/`crash_pulse` after edge N, i.e. one clock.
- Score latency: a `frame_tick` sampled at edge N shows as `score`+1 after edge N.
- CRASH lasts exactly CRASH_TICKS frame ticks. The exit happens on the edge that samples the CRASH_TICKS-th `frame_tick`.
- `crash_pulse` is high for exactly one clock per crash and never in consecutive cycles.
- Reset mid-game (any state): all outputs return to their reset values immediately (asynchronous), and the block waits in IDLE for a fresh `start_rise`.
- `start_btn` held high continuously produces only one `start_rise`.

## Test plan
All scenarios use LIVES=3 and CRASH_TICKS=4.

- **Start and score:** reset, `start_btn` 0→1, 10 `frame_tick`s.
  - `state`=01, `freeze`=0, `score`=10, `lives`=3.
- **Crash and invulnerability:** in PLAYING, pulse `collision` once.
  - `crash_pulse` high 1 cycle, `state`=10, `lives`=2.
  - `collision` held high for 3 ticks has no effect.
  - After the 4th tick, `state`=01.
  - `score` is unchanged throughout.
- **Game over:** three crashes, with a 4-tick recovery between each.
  - `lives` goes 2→1→0.
  - `state`=11, `game_over`=1, `score` held.
  - `start_rise` gives `lives`=3, `score`=0, `state`=01.
- **Collision beats tick:** `collision` and `frame_tick` asserted in the same cycle.
  - `score` does not increment; `state`=10.
- **Score saturation:** force `score` to 16'hFFFE, then apply 3 ticks.
  - `score`=16'hFFFF and stays there.
- **Reset mid-crash:** assert `reset` in CRASH with timer=2.
  - All outputs go to their reset values the same cycle.
  - `start_btn` held high through reset release does not start a game.
